// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared Tuse/Tnew encodings, MDU latencies and HI/LO decode constants for the hazard controller.
// Used by the decoder as well as by pipe_hazard_ctrl and md_busy_timer.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Opcode/funct values the decoder uses to raise E_md_start and D_md_use
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A producer blocks a consumer only if its result arrives strictly later than needed.
    function automatic logic data_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == dst) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// MDU occupancy timer: loads the operation latency when a mult/div enters E and counts down.
// busy_o is high for exactly N cycles following the start cycle.
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        // A start while busy is illegal upstream; if it happens the reload wins.
        if (start_i) begin
            cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
            state_d = MD_BUSY;
        end else begin
            case (state_q)
                MD_BUSY: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? MD_IDLE : MD_BUSY;
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: Tuse/Tnew data hazards plus HI/LO (MDU) hazards.
// Define HAZARD_STATS_EN to add saturating stall_count and md_stall_count outputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_md_use,
    input  logic [4:0]  E_dst_addr,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_dst_addr,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        stall_PC,
    output logic        stall_FD,
    output logic        flush_DE,
    output logic        md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] md_stall_count
`endif
);

    logic data_stall;
    logic md_stall;
    logic stall;

    assign data_stall = data_hazard(D_rs_addr, D_Tuse_rs, E_dst_addr, E_Tnew)
                      | data_hazard(D_rt_addr, D_Tuse_rt, E_dst_addr, E_Tnew)
                      | data_hazard(D_rs_addr, D_Tuse_rs, M_dst_addr, M_Tnew)
                      | data_hazard(D_rt_addr, D_Tuse_rt, M_dst_addr, M_Tnew);

    // E_md_start covers the first cycle, before the timer register has loaded.
    assign md_stall = D_md_use & (md_busy | E_md_start);
    assign stall    = data_stall | md_stall;

    assign stall_PC = stall;
    assign stall_FD = stall;
    assign flush_DE = stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (E_md_start),
        .is_div_i (E_md_is_div),
        .busy_o   (md_busy)
    );

`ifdef HAZARD_STATS_EN
    logic [31:0] stat_q   [2];
    logic [31:0] stat_d   [2];
    logic        stat_inc [2];

    assign stat_inc[0] = stall;
    assign stat_inc[1] = md_stall;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        always_comb begin
            stat_d[gi] = stat_q[gi];
            if (stat_inc[gi] && (stat_q[gi] != 32'hFFFF_FFFF))
                stat_d[gi] = stat_q[gi] + 32'd1;
        end

        always_ff @(posedge clk) begin
            if (reset)
                stat_q[gi] <= 32'd0;
            else
                stat_q[gi] <= stat_d[gi];
        end
    end

    assign stall_count    = stat_q[0];
    assign md_stall_count = stat_q[1];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic.
// Also checks the stall counters when built with HAZARD_STATS_EN.
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] D_rs_addr = '0, D_rt_addr = '0, E_dst_addr = '0, M_dst_addr = '0;
    logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, E_Tnew = '0, M_Tnew = '0;
    logic       D_md_use = 1'b0, E_md_start = 1'b0, E_md_is_div = 1'b0;
    logic       stall_PC, stall_FD, flush_DE, md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, md_stall_count;
`endif

    pipe_hazard_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_md_use    (D_md_use),
        .E_dst_addr  (E_dst_addr),
        .E_Tnew      (E_Tnew),
        .M_dst_addr  (M_dst_addr),
        .M_Tnew      (M_Tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .stall_PC    (stall_PC),
        .stall_FD    (stall_FD),
        .flush_DE    (flush_DE),
        .md_busy     (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count    (stall_count),
        .md_stall_count (md_stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, e_dst, m_dst;
        logic [1:0] tuse_rs, tuse_rt, e_tnew, m_tnew;
        logic       md_use, md_start, md_is_div, rst;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        stall;
        logic        busy;
        logic        start;
        logic [31:0] sc;
        logic [31:0] msc;
    } exp_t;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     busy_end = -1;   // last cycle in which the MDU is still occupied
    longint sc_m = 0, msc_m = 0;

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        s.tuse_rs = 2'd3;
        s.tuse_rt = 2'd3;
        return s;
    endfunction

    function automatic logic ref_hz(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] dst, input logic [1:0] tnew);
        return (src != 0) && (src == dst) && (int'(tnew) > int'(tuse));
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the response, then advance the clock.
    task automatic step(input stim_t s);
        exp_t e;
        logic busy, md_hz, data_hz;
        D_rs_addr = s.rs;        D_rt_addr = s.rt;
        D_Tuse_rs = s.tuse_rs;   D_Tuse_rt = s.tuse_rt;
        D_md_use = s.md_use;
        E_dst_addr = s.e_dst;    E_Tnew = s.e_tnew;
        M_dst_addr = s.m_dst;    M_Tnew = s.m_tnew;
        E_md_start = s.md_start; E_md_is_div = s.md_is_div;
        reset = s.rst;

        busy    = (cyc <= busy_end);
        md_hz   = s.md_use && (busy || s.md_start);
        data_hz = ref_hz(s.rs, s.tuse_rs, s.e_dst, s.e_tnew) || ref_hz(s.rt, s.tuse_rt, s.e_dst, s.e_tnew)
               || ref_hz(s.rs, s.tuse_rs, s.m_dst, s.m_tnew) || ref_hz(s.rt, s.tuse_rt, s.m_dst, s.m_tnew);
        e.cyc   = cyc;
        e.stall = data_hz || md_hz;
        e.busy  = busy;
        e.start = s.md_start;
        e.sc    = sc_m[31:0];
        e.msc   = msc_m[31:0];
        sb_q.push_back(e);

        if (s.rst) begin
            busy_end = cyc;
            sc_m = 0;
            msc_m = 0;
        end else begin
            if (s.md_start) busy_end = cyc + (s.md_is_div ? DIV_N : MULT_N);
            if (e.stall && sc_m < 64'hFFFF_FFFF) sc_m++;
            if (md_hz && msc_m < 64'hFFFF_FFFF) msc_m++;
        end
        $display("cyc=%0d rs=%0d rt=%0d E=%0d/%0d M=%0d/%0d md_use=%0b start=%0b div=%0b rst=%0b exp_stall=%0b exp_busy=%0b",
                 cyc, s.rs, s.rt, s.e_dst, s.e_tnew, s.m_dst, s.m_tnew, s.md_use, s.md_start, s.md_is_div,
                 s.rst, e.stall, e.busy);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stall_PC", e.cyc, 32'(stall_PC), 32'(e.stall));
            chk("stall_FD", e.cyc, 32'(stall_FD), 32'(e.stall));
            chk("flush_DE", e.cyc, 32'(flush_DE), 32'(e.stall));
            chk("md_busy",  e.cyc, 32'(md_busy),  32'(e.busy));
            if (e.start) chk("start_while_busy", e.cyc, 32'(md_busy), 32'd0);
`ifdef HAZARD_STATS_EN
            chk("stall_count",    e.cyc, stall_count,    e.sc);
            chk("md_stall_count", e.cyc, md_stall_count, e.msc);
`endif
        end
    end

    initial begin
        stim_t s;
        @(posedge clk);
        #1;
        s = nop(); s.rst = 1'b1;
        step(s);
        step(s);

        // Load-use stall, then the producer in M is forwardable
        s = nop(); s.e_dst = 8; s.e_tnew = 2; s.rs = 8; s.tuse_rs = 1;
        step(s);
        s = nop(); s.m_dst = 8; s.m_tnew = 1; s.rs = 8; s.tuse_rs = 1;
        step(s);

        // Forwardable cases from E and from M
        s = nop(); s.e_dst = 8; s.e_tnew = 1; s.rs = 8; s.tuse_rs = 1;
        step(s);
        s = nop(); s.m_dst = 9; s.m_tnew = 0; s.rt = 9; s.tuse_rt = 0;
        step(s);

        // $0 never stalls
        s = nop(); s.e_dst = 0; s.e_tnew = 2; s.rs = 0; s.tuse_rs = 0;
        step(s);

        // div followed by mflo held in D until the MDU drains
        s = nop(); s.md_start = 1; s.md_is_div = 1; s.md_use = 1;
        step(s);
        s = nop(); s.md_use = 1;
        for (int i = 0; i < DIV_N + 1; i++) step(s);

        // mult with an unrelated addu in D
        s = nop(); s.md_start = 1; s.rs = 4; s.tuse_rs = 1; s.rt = 5; s.tuse_rt = 1; s.e_dst = 6; s.e_tnew = 1;
        step(s);
        s = nop(); s.rs = 4; s.tuse_rs = 1;
        for (int i = 0; i < MULT_N + 1; i++) step(s);

        // Reset in the middle of a div releases the mflo
        s = nop(); s.md_start = 1; s.md_is_div = 1; s.md_use = 1;
        step(s);
        s = nop(); s.md_use = 1;
        step(s);
        step(s);
        s.rst = 1;
        step(s);
        s.rst = 0;
        step(s);
        step(s);

        // Random traffic; starts are only issued while the MDU is free
        for (int i = 0; i < 600; i++) begin
            s = nop();
            s.rs = 5'($urandom_range(0, 3));
            s.rt = 5'($urandom_range(0, 3));
            s.e_dst = 5'($urandom_range(0, 3));
            s.m_dst = 5'($urandom_range(0, 3));
            s.tuse_rs = 2'($urandom_range(0, 3));
            s.tuse_rt = 2'($urandom_range(0, 3));
            s.e_tnew = 2'($urandom_range(0, 2));
            s.m_tnew = 2'($urandom_range(0, 1));
            s.md_use = ($urandom_range(0, 3) == 0);
            s.md_start = (cyc > busy_end) && ($urandom_range(0, 7) == 0);
            s.md_is_div = 1'($urandom_range(0, 1));
            s.rst = ($urandom_range(0, 59) == 0);
            step(s);
        end

        s = nop();
        D_rs_addr = s.rs;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
